// File: rtl/ld_st_exec_pipe_pkg.sv
// ld_st_exec_pipe_pkg: access-size encoding, CDB record and lane/extension helpers for the load/store pipe
package ld_st_exec_pipe_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_WX = 2'b11} size_e;
  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;
  localparam int XLEN = 32;
  typedef struct packed {
    logic            valid;
    logic [5:0]      tag;
    logic [XLEN-1:0] result;
    logic            misalign;
  } cdb_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_H && lo[0]) || (size[1] && lo != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    return size[1] ? 4'hf : size[0] ? 4'b0011 << lo : 4'b0001 << lo;
  endfunction
  function automatic logic [XLEN-1:0] lane_shift(input logic [XLEN-1:0] d, input logic [1:0] lo);
    return d << {lo, 3'b000};
  endfunction
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lo);
    logic [XLEN-1:0] s;
    s = d >> {lo, 3'b000};
    return size[1] ? s : size[0] ? {{16{~uns & s[15]}}, s[15:0]} : {{24{~uns & s[7]}}, s[7:0]};
  endfunction
endpackage

// File: rtl/ld_st_exec_pipe_ram.sv
// ld_st_ram: byte-enable write, synchronous read-with-enable data RAM
module ld_st_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/ld_st_exec_pipe.sv
// ld_st_exec_pipe: load/store execution unit with sized access, misalign detect, CDB backpressure and flush
module ld_st_exec_pipe
  import ld_st_exec_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int TAG_WIDTH  = 6,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_store,
  input  logic [1:0]            issue_size,
  input  logic                  issue_unsigned,
  input  logic [DATA_WIDTH-1:0] issue_base,
  input  logic [DATA_WIDTH-1:0] issue_imm,
  input  logic [DATA_WIDTH-1:0] issue_wdata,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  input  logic                  issue_wb_valid,
  input  logic                  cdb_ready,
  output logic                  cdb_valid,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  cdb_misalign
);
  typedef struct packed {
    logic                 valid;
    logic                 bcast;
    logic [TAG_WIDTH-1:0] tag;
    logic [1:0]           size;
    logic                 uns;
    logic [1:0]           lane;
    logic                 mis;
  } entry_t;
  logic [ADDR_WIDTH+1:0] ea;
  logic                  ea_mis, advance, accept;
  logic [DATA_WIDTH-1:0] rdata, fin_d;
  entry_t                nxt, fin;
  assign ea          = issue_base[ADDR_WIDTH+1:0] + issue_imm[ADDR_WIDTH+1:0];
  assign ea_mis      = is_misaligned(issue_size, ea[1:0]);
  assign advance     = ~(cdb_valid & ~cdb_ready);
  assign issue_ready = advance & ~flush;
  assign accept      = issue_valid & issue_ready;
  assign nxt = '{valid: issue_valid,
                 bcast: ea_mis | (issue_store == OP_LD & issue_wb_valid),
                 tag: issue_tag, size: issue_size, uns: issue_unsigned,
                 lane: ea[1:0], mis: ea_mis};
  // a store coinciding with rst is discarded along with everything in flight
  ld_st_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (accept & issue_store & ~ea_mis & ~rst),
    .be    (byte_en(issue_size, ea[1:0])),
    .addr  (ea[ADDR_WIDTH+1:2]),
    .wdata (lane_shift(issue_wdata, ea[1:0])),
    .re    (advance),
    .rdata (rdata)
  );
  // stage 0 data is the RAM output itself; later stages carry it along with the entry
  for (genvar i = 0; i < LATENCY; i++) begin : st
    entry_t                e;
    logic [DATA_WIDTH-1:0] d;
    if (i == 0) begin : g_first
      assign d = rdata;
      always_ff @(posedge clk)
        if (rst || flush) e <= '0;
        else if (advance) e <= nxt;
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst || flush) e <= '0;
        else if (advance) e <= st[i-1].e;
        if (advance) d <= st[i-1].d;
      end
    end
  end
  assign fin          = st[LATENCY-1].e;
  assign fin_d        = st[LATENCY-1].d;
  assign cdb_valid    = fin.valid & fin.bcast;
  assign cdb_tag      = cdb_valid ? fin.tag : '0;
  assign cdb_result   = (cdb_valid & ~fin.mis) ? extend(fin_d, fin.size, fin.uns, fin.lane) : '0;
  assign cdb_misalign = cdb_valid & fin.mis;
endmodule

// File: tb/tb_ld_st_exec_pipe.sv
// tb_ld_st_exec_pipe: directed self-checking bench for the load/store execution pipe
module tb_ld_st_exec_pipe;
  localparam int LAT = 2;
  logic        clk = 0, rst = 1, flush = 0;
  logic        issue_valid = 0, issue_ready, issue_store = 0, issue_unsigned = 0, issue_wb_valid = 0;
  logic [1:0]  issue_size = 0;
  logic [31:0] issue_base = 0, issue_imm = 0, issue_wdata = 0;
  logic [5:0]  issue_tag = 0;
  logic        cdb_ready = 1, cdb_valid, cdb_misalign;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;
  int compared = 0, mismatched = 0;

  ld_st_exec_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .TAG_WIDTH(6), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_store(issue_store),
    .issue_size(issue_size), .issue_unsigned(issue_unsigned), .issue_base(issue_base),
    .issue_imm(issue_imm), .issue_wdata(issue_wdata), .issue_tag(issue_tag),
    .issue_wb_valid(issue_wb_valid), .cdb_ready(cdb_ready), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_misalign(cdb_misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wd, input logic [5:0] tg, input logic wb);
    issue_valid = 1; issue_store = st; issue_size = sz; issue_unsigned = uns;
    issue_base = base; issue_imm = imm; issue_wdata = wd; issue_tag = tg; issue_wb_valid = wb;
  endtask

  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wd, input logic [5:0] tg, input logic wb);
    drive(st, sz, uns, base, imm, wd, tg, wb);
    step();
    issue_valid = 0;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] ea, input logic [5:0] tg);
    do_op(0, sz, uns, ea, 0, 0, tg, 1);
    repeat (LAT - 1) step();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) step();
    rst = 0;
    compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", cdb_valid); end
    compared++; if (cdb_tag !== 6'd0) begin mismatched++; $display("FAIL reset_tag: got %h expected 0", cdb_tag); end
    compared++; if (cdb_result !== 32'd0) begin mismatched++; $display("FAIL reset_result: got %h expected 0", cdb_result); end
    compared++; if (cdb_misalign !== 1'b0) begin mismatched++; $display("FAIL reset_misalign: got %b expected 0", cdb_misalign); end
    compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
  endtask

  task automatic test_store_load();
    do_op(1, 2'b10, 0, 32'h10, 32'h4, 32'hDEADBEEF, 6'd3, 0);
    for (int c = 0; c < LAT + 1; c++) begin
      compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL store_no_bcast c%0d: got %b expected 0", c, cdb_valid); end
      step();
    end
    do_op(0, 2'b10, 0, 32'h10, 32'h4, 0, 6'd5, 1);
    compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL lw_early: got %b expected 0", cdb_valid); end
    repeat (LAT - 1) step();
    compared++; if (cdb_valid !== 1'b1) begin mismatched++; $display("FAIL lw_valid: got %b expected 1", cdb_valid); end
    compared++; if (cdb_tag !== 6'd5) begin mismatched++; $display("FAIL lw_tag: got %h expected 05", cdb_tag); end
    compared++; if (cdb_result !== 32'hDEADBEEF) begin mismatched++; $display("FAIL lw_result: got %h expected deadbeef", cdb_result); end
    compared++; if (cdb_misalign !== 1'b0) begin mismatched++; $display("FAIL lw_misalign: got %b expected 0", cdb_misalign); end
    step();
    compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL lw_single: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_extend();
    do_load(2'b00, 0, 32'h15, 6'd1);
    compared++; if (cdb_result !== 32'hFFFFFFBE) begin mismatched++; $display("FAIL lb: got %h expected ffffffbe", cdb_result); end
    do_load(2'b00, 1, 32'h15, 6'd2);
    compared++; if (cdb_result !== 32'h000000BE) begin mismatched++; $display("FAIL lbu: got %h expected 000000be", cdb_result); end
    do_load(2'b01, 0, 32'h16, 6'd3);
    compared++; if (cdb_result !== 32'hFFFFDEAD) begin mismatched++; $display("FAIL lh: got %h expected ffffdead", cdb_result); end
    do_load(2'b01, 1, 32'h14, 6'd4);
    compared++; if (cdb_result !== 32'h0000BEEF) begin mismatched++; $display("FAIL lhu: got %h expected 0000beef", cdb_result); end
    do_load(2'b00, 1, 32'h17, 6'd6);
    compared++; if (cdb_result !== 32'h000000DE) begin mismatched++; $display("FAIL lbu_top: got %h expected 000000de", cdb_result); end
    step();
  endtask

  task automatic test_misalign();
    do_op(0, 2'b10, 0, 32'h10, 32'h3, 0, 6'd7, 0);
    repeat (LAT - 1) step();
    compared++; if (cdb_valid !== 1'b1) begin mismatched++; $display("FAIL mis_lw_valid: got %b expected 1", cdb_valid); end
    compared++; if (cdb_misalign !== 1'b1) begin mismatched++; $display("FAIL mis_lw_flag: got %b expected 1", cdb_misalign); end
    compared++; if (cdb_result !== 32'd0) begin mismatched++; $display("FAIL mis_lw_result: got %h expected 0", cdb_result); end
    compared++; if (cdb_tag !== 6'd7) begin mismatched++; $display("FAIL mis_lw_tag: got %h expected 07", cdb_tag); end
    step();
    do_op(1, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 6'd8, 0);
    do_op(1, 2'b01, 0, 32'h20, 32'h1, 32'h00001234, 6'd9, 0);
    repeat (LAT - 1) step();
    compared++; if (cdb_valid !== 1'b1 || cdb_misalign !== 1'b1) begin mismatched++; $display("FAIL mis_sh_bcast: got v=%b m=%b expected v=1 m=1", cdb_valid, cdb_misalign); end
    compared++; if (cdb_tag !== 6'd9 || cdb_result !== 32'd0) begin mismatched++; $display("FAIL mis_sh_fields: got tag=%h res=%h expected tag=09 res=0", cdb_tag, cdb_result); end
    step();
    do_op(1, 2'b00, 0, 32'h20, 32'h2, 32'h00000077, 6'd10, 0);
    do_load(2'b10, 0, 32'h20, 6'd11);
    compared++; if (cdb_result !== 32'hCA77F00D) begin mismatched++; $display("FAIL sb_merge: got %h expected ca77f00d", cdb_result); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pr;
    logic [5:0]  pt;
    logic        pv;
    int k, n, held;
    for (int j = 0; j < 4; j++) begin
      do_op(1, 2'b10, 0, 32'h30 + 32'(4*j), 0, 32'h11111111 * (j + 1), 6'd0, 0);
      compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_store_bcast %0d: got %b expected 0", j, cdb_valid); end
    end
    k = 0; n = 0; held = 0; pv = 0; pr = 0; pt = 0;
    for (int c = 0; c < 30; c++) begin
      cdb_ready = !(cdb_valid && held < 3);
      if (k < 4) drive(0, 2'b10, 0, 32'h30 + 32'(4*k), 0, 0, 6'(k + 1), 1);
      else issue_valid = 0;
      #1;
      if (!cdb_ready) begin
        held++;
        compared++; if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_stall: got %b expected 0", issue_ready); end
        if (pv) begin
          compared++; if (cdb_result !== pr || cdb_tag !== pt) begin mismatched++; $display("FAIL b2b_hold: got %h/%h expected %h/%h", cdb_tag, cdb_result, pt, pr); end
        end
      end
      pv = cdb_valid && !cdb_ready; pr = cdb_result; pt = cdb_tag;
      if (cdb_valid && cdb_ready) begin
        compared++;
        if (n >= 4 || cdb_tag !== 6'(n + 1) || cdb_result !== 32'h11111111 * (n + 1)) begin
          mismatched++; $display("FAIL b2b_order %0d: got tag=%h res=%h expected tag=%h res=%h", n, cdb_tag, cdb_result, 6'(n + 1), 32'h11111111 * (n + 1));
        end
        n++;
      end
      if (issue_valid && issue_ready) k++;
      @(posedge clk); #1;
    end
    issue_valid = 0; cdb_ready = 1;
    compared++; if (n !== 4) begin mismatched++; $display("FAIL b2b_count: got %0d expected 4", n); end
    compared++; if (held !== 3) begin mismatched++; $display("FAIL b2b_stall_len: got %0d expected 3", held); end
  endtask

  task automatic test_flush();
    do_op(1, 2'b10, 0, 32'h40, 0, 32'h5A5A5A5A, 6'd0, 0);
    do_op(1, 2'b10, 0, 32'h44, 0, 32'h00000000, 6'd0, 0);
    do_op(0, 2'b10, 0, 32'h40, 0, 0, 6'd11, 1);
    cdb_ready = 0;
    do_op(0, 2'b10, 0, 32'h44, 0, 0, 6'd12, 1);
    flush = 1;
    drive(1, 2'b10, 0, 32'h44, 0, 32'h99999999, 6'd0, 0);
    #1;
    compared++; if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
    @(posedge clk); #1;
    flush = 0; issue_valid = 0; cdb_ready = 1;
    compared++; if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0) begin mismatched++; $display("FAIL flush_clear: got v=%b tag=%h expected v=0 tag=0", cdb_valid, cdb_tag); end
    for (int c = 0; c < 3; c++) begin
      step();
      compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL flush_no_bcast c%0d: got %b expected 0", c, cdb_valid); end
    end
    do_load(2'b10, 0, 32'h40, 6'd13);
    compared++; if (cdb_result !== 32'h5A5A5A5A || cdb_tag !== 6'd13) begin mismatched++; $display("FAIL flush_store_kept: got %h/%h expected 0d/5a5a5a5a", cdb_tag, cdb_result); end
    do_load(2'b10, 0, 32'h44, 6'd14);
    compared++; if (cdb_result !== 32'h00000000) begin mismatched++; $display("FAIL flush_no_accept: got %h expected 00000000", cdb_result); end
    step();
  endtask

  task automatic test_reset_mid();
    do_op(1, 2'b10, 0, 32'h50, 0, 32'h13572468, 6'd0, 0);
    do_op(0, 2'b10, 0, 32'h50, 0, 0, 6'd20, 1);
    rst = 1;
    drive(1, 2'b10, 0, 32'h50, 0, 32'hFFFFFFFF, 6'd21, 0);
    step();
    rst = 0; issue_valid = 0;
    compared++; if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_result !== 32'd0 || cdb_misalign !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid_outputs: got v=%b t=%h r=%h m=%b expected all 0", cdb_valid, cdb_tag, cdb_result, cdb_misalign);
    end
    step();
    compared++; if (cdb_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_dropped: got %b expected 0", cdb_valid); end
    do_load(2'b10, 0, 32'h50, 6'd22);
    compared++; if (cdb_result !== 32'h13572468) begin mismatched++; $display("FAIL rst_mid_store: got %h expected 13572468", cdb_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_misalign();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ld_st_exec_pipe.md
# ld_st_exec_pipe

Parametrised load/store execution unit for the Tomasulo RISC-V core. It sits between the load/store issue queue and the CDB arbiter, and replaces the single-latency word-only memory executor. It adds byte/half/word access with sign/zero extension, misalignment detection, a ready/valid issue handshake, CDB backpressure and a mispredict flush. Loads return on the CDB after a configurable pipeline depth; stores write the internal data RAM at acceptance.

## Interface
- DATA_WIDTH, 32, data/address width
- ADDR_WIDTH, 7, RAM word-index width (depth 2^ADDR_WIDTH words)
- TAG_WIDTH, 6, ROB/CDB tag width
- LATENCY, 2, issue-to-CDB cycles for loads; legal range 1..8
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  mispredict flush of in-flight loads
- issue_valid  in  1  issue queue presents an op
- issue_ready  out  1  op accepted this cycle when high with issue_valid
- issue_store  in  1  0 load, 1 store
- issue_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- issue_unsigned  in  1  zero-extend loads (LBU/LHU)
- issue_base  in  DATA_WIDTH  rs1 data
- issue_imm  in  DATA_WIDTH  sign-extended immediate
- issue_wdata  in  DATA_WIDTH  rs2 data (stores)
- issue_tag  in  TAG_WIDTH  rd/ROB tag
- issue_wb_valid  in  1  load result must be broadcast
- cdb_ready  in  1  arbiter grant for this unit
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_WIDTH  broadcast tag
- cdb_result  out  DATA_WIDTH  load data, extended
- cdb_misalign  out  1  access was misaligned

## Operation
- Effective address ea = issue_base + issue_imm, modulo 2^DATA_WIDTH. Word index = ea[ADDR_WIDTH+1:2]; upper bits are ignored, so addresses wrap over the RAM.
- Misaligned access: half with ea[0]=1, or word with ea[1:0]≠0.
- Accept = issue_valid & issue_ready.
- Aligned store: the RAM is written at the accept edge with byte enables from size and ea[1:0]. Data is lane-shifted.
- Aligned store: cdb_valid is never raised for it. The store still occupies one slot in the pipeline as a non-broadcasting entry.
- Misaligned store: RAM is not written. It travels the pipe and broadcasts with cdb_misalign=1, result 0, its tag.
- Load: the RAM is read synchronously with enable = advance. Data is lane-selected by ea[1:0] and extended per issue_size/issue_unsigned at the final stage.
- Load broadcast: cdb_valid = entry valid & wb_valid, or misaligned.
- Misaligned load: result 0, cdb_misalign=1, cdb_valid=1 regardless of wb_valid.
- Pipeline: LATENCY entry registers; each entry holds {valid, bcast, tag, size, unsigned, lane, misalign}.
- Stall: stall = cdb_valid & ~cdb_ready. advance = ~stall. issue_ready = advance & ~flush.
- When stalled, every stage holds, including the captured RAM data; bubbles are not collapsed.
- flush: at the edge, all entry valids clear. Stores already written remain in RAM. No op is accepted in a flush cycle.
- RAM contents are not affected by rst or flush.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_result=0, cdb_misalign=0, all entry valids 0. issue_ready=1 in the first cycle after rst deasserts.
- rst asserted mid-operation drops all in-flight loads. A store whose accept edge coincides with rst is not written.
- Load accepted at edge N presents on the CDB in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later with no stall. Each stall cycle adds one.
- Back-to-back issue: one op per cycle, sustained at full throughput while cdb_ready=1.
- Store then load to the same word on consecutive accepts: the load returns the new data (write-before-read ordering across cycles).
- cdb_* outputs are held stable while stalled.
- Simultaneous flush & stall: flush wins; outputs clear next cycle.

## Structure
- Shared package (utils.sv): size encoding enum, ld/st opcode constant, and the CDB record type (cdb_bfm with added misalign field). Pipeline entry struct is local.
- One sub-module: ld_st_ram, a byte-enable write, synchronous read-with-enable RAM with parameters DATA_WIDTH and ADDR_WIDTH.
- Lane select, extension and misalignment checks are functions in the package.

## Test plan
- After rst, SW base=0x10 imm=4 data=0xDEADBEEF, then LW tag=5 same ea with LATENCY=2 -> cdb_valid, tag 5, result 0xDEADBEEF two cycles after load accept; the store never raises cdb_valid.
- LB at ea=0x15 after the above word at 0x14 (bytes EF,BE,AD,DE) -> 0xFFFFFFBE. LBU -> 0x000000BE. LH at 0x16 -> 0xFFFFDEAD.
- LW at ea=0x13 tag 7 -> cdb_misalign=1, result 0. SH at ea=0x21 -> RAM unchanged, misalign broadcast with its tag.
- Four back-to-back loads with cdb_ready low for 3 cycles at the first result -> issue_ready low during the stall, results in order, none lost or duplicated, outputs stable while held.
- Two loads in flight, flush asserted -> no broadcast for either; a store accepted before the flush still reads back correctly later.
- rst pulse while a load is in flight and a store is presented -> no broadcast, store not written, all outputs 0 next cycle.
